// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline sequencing for a 5-stage core: stage enables/flushes, load-use stall,
// branch/jump squash, multi-cycle data-memory wait with sticky timeout, stall counter.
module pipeline_hazard_ctrl #(
  parameter int REG_AW      = 5,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_uses_rt,
  input  logic              id_jump,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              ex_mem_read,
  input  logic              mem_branch_taken,
  input  logic              mem_req,
  input  logic              mem_ack,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              id_ex_en,
  output logic              ex_mem_en,
  output logic              mem_wb_en,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              ex_mem_flush,
  output logic              mem_err,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [1:0]        fsm_state
);

  // Memory handshake: mem_req is a level held by EX/MEM until mem_ack;
  // the access completes on the cycle mem_ack is high.
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  localparam int              WCW    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCW-1:0]  TO_VAL = WCW'(MEM_TIMEOUT);

  state_t         state;
  logic [WCW-1:0] wait_cnt;
  logic           mem_err_q;
  logic           load_use;
  logic           frozen;

  assign load_use = ex_mem_read && (ex_rt != '0) &&
                    ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));

  always_comb begin
    frozen = 1'b1;
    case (state)
      RUN:      frozen = mem_req && !mem_ack;
      MEM_WAIT: frozen = !mem_ack;
      ERR:      frozen = 1'b1;
      default:  frozen = 1'b1;
    endcase
  end

  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    id_ex_en     = 1'b1;
    ex_mem_en    = 1'b1;
    mem_wb_en    = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    if (!reset) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_en    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (frozen) begin
      pc_en     = 1'b0;
      if_id_en  = 1'b0;
      id_ex_en  = 1'b0;
      ex_mem_en = 1'b0;
      mem_wb_en = 1'b0;
    end else if (mem_branch_taken) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else if (load_use) begin
      // Hold PC and IF/ID; the bubble into ID/EX clears the hazard next cycle.
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end else if (id_jump) begin
      if_id_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RUN;
      wait_cnt  <= '0;
      mem_err_q <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (!pc_en && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      case (state)
        RUN: begin
          if (mem_req && !mem_ack) begin
            state    <= MEM_WAIT;
            wait_cnt <= WCW'(1);
          end
        end
        MEM_WAIT: begin
          if (mem_ack) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == TO_VAL) begin
            state     <= ERR;
            mem_err_q <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        ERR:     mem_err_q <= 1'b1;
        default: state <= RUN;
      endcase
    end
  end

  assign mem_err   = mem_err_q;
  assign fsm_state = state;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized + directed bench for pipeline_hazard_ctrl against a rule-level reference model.
module tb_pipeline_hazard_ctrl;
  localparam int REG_AW = 5;
  localparam int TO     = 4;
  localparam int CNT_W  = 4;
  localparam int CMAX   = (1 << CNT_W) - 1;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [REG_AW-1:0] id_rs, id_rt, ex_rt;
  logic id_uses_rt, id_jump, ex_mem_read, mem_branch_taken, mem_req, mem_ack;
  logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic if_id_flush, id_ex_flush, ex_mem_flush, mem_err;
  logic [CNT_W-1:0] stall_cnt;
  logic [1:0] fsm_state;

  pipeline_hazard_ctrl #(.REG_AW(REG_AW), .MEM_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_jump(id_jump),
    .ex_rt(ex_rt), .ex_mem_read(ex_mem_read), .mem_branch_taken(mem_branch_taken),
    .mem_req(mem_req), .mem_ack(mem_ack),
    .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en),
    .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .ex_mem_flush(ex_mem_flush), .mem_err(mem_err), .stall_cnt(stall_cnt),
    .fsm_state(fsm_state)
  );

  logic [7:0] act_vec;
  assign act_vec = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                    if_id_flush, id_ex_flush, ex_mem_flush};

  // scoreboard counters
  int n_cmp = 0;
  int n_bad = 0;

  // reference model: memory-wait progress, sticky error, stall total
  bit m_err;
  bit m_waiting;
  int m_wait_n;
  int m_stalls;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit model_frozen();
    if (m_err) return 1'b1;
    if (m_waiting) return !mem_ack;
    return mem_req && !mem_ack;
  endfunction

  // Expected {pc,if_id,id_ex,ex_mem,mem_wb enables, if_id,id_ex,ex_mem flushes}
  function automatic logic [7:0] model_vec();
    int rs, rt, ert;
    bit lu;
    rs  = int'(id_rs);
    rt  = int'(id_rt);
    ert = int'(ex_rt);
    lu  = ex_mem_read && ert != 0 && (ert == rs || (id_uses_rt && ert == rt));
    if (!reset)           return 8'b00000_111;
    if (model_frozen())   return 8'b00000_000;
    if (mem_branch_taken) return 8'b11111_111;
    if (lu)               return 8'b00111_010;
    if (id_jump)          return 8'b11111_100;
    return 8'b11111_000;
  endfunction

  task automatic idle();
    id_rs = '0; id_rt = '0; ex_rt = '0;
    id_uses_rt = 0; id_jump = 0; ex_mem_read = 0;
    mem_branch_taken = 0; mem_req = 0; mem_ack = 0;
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic cycle(input string tag);
    logic [7:0] e;
    bit fz;
    #1;
    e  = model_vec();
    fz = model_frozen();
    check({tag, ":ctl"}, 32'(act_vec), 32'(e));
    check({tag, ":err"}, 32'(mem_err), 32'(m_err));
    check({tag, ":cnt"}, 32'(stall_cnt), 32'(m_stalls));
    @(posedge clk);
    if (!fz) m_waiting = 0;
    else if (!m_err) begin
      if (!m_waiting) begin
        m_waiting = 1;
        m_wait_n  = 1;
      end else if (m_wait_n == TO) m_err = 1;
      else m_wait_n++;
    end
    if (!e[7] && m_stalls < CMAX) m_stalls++;
    @(negedge clk);
  endtask

  task automatic apply_reset(input string tag);
    #2 reset = 1'b0;
    m_err = 0; m_waiting = 0; m_wait_n = 0; m_stalls = 0;
    #1;
    check({tag, ":rst_ctl"}, 32'(act_vec), 32'h07);
    check({tag, ":rst_err"}, 32'(mem_err), 32'h0);
    check({tag, ":rst_cnt"}, 32'(stall_cnt), 32'h0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    idle();
    reset = 1'b0;
    m_err = 0; m_waiting = 0; m_wait_n = 0; m_stalls = 0;
    repeat (2) @(negedge clk);
    check("reset_ctl", 32'(act_vec), 32'h07);
    check("reset_cnt", 32'(stall_cnt), 32'h0);
    reset = 1'b1;

    // T1 load-use on rs
    ex_mem_read = 1; ex_rt = 5; id_rs = 5;
    cycle("t1_stall");
    check("t1_stall_cnt", 32'(stall_cnt), 32'd1);
    ex_mem_read = 0;
    cycle("t1_after");

    // T2 no hazard
    idle(); ex_mem_read = 1; ex_rt = 0; id_rs = 0;
    cycle("t2_zero");
    ex_rt = 7; id_rt = 7; id_uses_rt = 0; id_rs = 3;
    cycle("t2_no_rt");
    id_uses_rt = 1;
    cycle("t2_rt_stall");

    // T3 branch beats load-use and jump
    idle(); mem_branch_taken = 1; ex_mem_read = 1; ex_rt = 4; id_rs = 4; id_jump = 1;
    cycle("t3_branch");
    mem_branch_taken = 0;
    cycle("t3_lu_over_jump");
    ex_mem_read = 0;
    cycle("t3_jump");

    // T4 memory wait, 3 frozen cycles then ack
    idle(); apply_reset("t4");
    mem_req = 1;
    repeat (3) cycle("t4_wait");
    mem_ack = 1;
    cycle("t4_ack");
    check("t4_stall_cnt", 32'(stall_cnt), 32'd3);
    idle();
    cycle("t4_run");

    // T5 timeout, sticky error, counter saturation
    apply_reset("t5");
    mem_req = 1;
    repeat (5) cycle("t5_frozen");
    check("t5_err_set", 32'(mem_err), 32'd1);
    mem_ack = 1;
    repeat (14) cycle("t5_sticky");
    check("t5_saturate", 32'(stall_cnt), 32'(CMAX));
    apply_reset("t5_clear");
    idle();
    cycle("t5_run");

    // T6 async reset in the middle of a wait
    mem_req = 1;
    repeat (2) cycle("t6_wait");
    apply_reset("t6");
    idle();
    cycle("t6_run");

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      id_rs            = REG_AW'($urandom_range(0, 3));
      id_rt            = REG_AW'($urandom_range(0, 3));
      ex_rt            = REG_AW'($urandom_range(0, 3));
      id_uses_rt       = $urandom_range(0, 1);
      id_jump          = ($urandom_range(0, 4) == 0);
      ex_mem_read      = $urandom_range(0, 1);
      mem_branch_taken = ($urandom_range(0, 5) == 0);
      mem_req          = ($urandom_range(0, 3) == 0);
      mem_ack          = ($urandom_range(0, 2) != 0);
      if ((m_err && $urandom_range(0, 7) == 0) || $urandom_range(0, 99) == 0)
        apply_reset("rnd");
      cycle("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
